// File: rtl/mem_access_unit_pkg.sv
// Shared size encodings, FSM state codes and request legality helper
// for the load/store initiator.
package mem_access_unit_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    DONE = 2'b11
  } state_t;

  // Reserved size, odd halfword or non-word-aligned word.
  function automatic logic bad_size_align(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return off[0];
      SIZE_W:  return |off;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_byte_lane_mux.sv
// Little-endian lane extract (with sign/zero extension) and lane merge
// for byte and halfword accesses within a 32-bit word.
module byte_lane_mux
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [15:0] data,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] extract,
  output logic [31:0] merge
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{off, 3'b000} +: 8];
    half_sel = off[1] ? word[31:16] : word[15:0];
    extract  = word;
    merge    = word;
    case (size)
      SIZE_B: begin
        extract = {{24{sign & byte_sel[7]}}, byte_sel};
        merge[{off, 3'b000} +: 8] = data[7:0];
      end
      SIZE_H: begin
        extract = {{16{sign & half_sel[15]}}, half_sel};
        merge[{off[1], 4'b0000} +: 16] = data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between the CPU datapath and word-wide data memory;
// sub-word stores are done as read-modify-write of the containing word.
//
// state | meaning
// IDLE  | waiting for req; request fields captured on accept
// RD    | one-cycle memory read (load data or RMW source word)
// WR    | one-cycle memory write (word store or merged word)
// DONE  | done pulse, err valid; req ignored
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int MEM_AW      = 8,
  parameter bit RANGE_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        r_st,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_wr,
  input  logic [31:0] mem_data_rd
);

  state_t      state, state_nxt;
  logic        we_q, sign_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, merge_q;
  logic        req_err;
  logic [31:0] extract_w, merge_w;

  assign req_err = bad_size_align(size, addr[1:0]) |
                   (RANGE_CHECK & (|addr[31:MEM_AW]));

  byte_lane_mux u_lane (
    .word    (mem_data_rd),
    .data    (wdata_q[15:0]),
    .off     (addr_q[1:0]),
    .size    (size_q),
    .sign    (sign_q),
    .extract (extract_w),
    .merge   (merge_w)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (req_err)                   state_nxt = DONE;
          else if (!we || size != SIZE_W) state_nxt = RD;
          else                           state_nxt = WR;
        end
      end
      RD:      state_nxt = we_q ? WR : DONE;
      WR:      state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge r_st) begin
    if (!r_st) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SIZE_B;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req) begin
        we_q    <= we;
        sign_q  <= sign_ext;
        err_q   <= req_err;
        size_q  <= size;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (state == RD) begin
        if (we_q) merge_q <= merge_w;
        else      rdata   <= extract_w;
      end
    end
  end

  // Outputs decode straight from state so an async reset drops them at once.
  assign done        = (state == DONE);
  assign err         = (state == DONE) & err_q;
  assign busy        = (state != IDLE);
  assign mem_rd_en   = (state == RD);
  assign mem_wr_en   = (state == WR);
  assign mem_addr    = {addr_q[31:2], 2'b00};
  assign mem_data_wr = (state == WR) ? ((size_q == SIZE_W) ? wdata_q : merge_q) : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected responses,
// a negedge monitor pops and compares on every done pulse.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0, r_st = 1'b0, req = 1'b0, we = 1'b0, sign_ext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata, mem_addr, mem_data_wr, mem_data_rd;
  logic        done, err, busy, mem_wr_en, mem_rd_en;

  mem_access_unit #(.MEM_AW(8), .RANGE_CHECK(1'b1)) dut (
    .clk(clk), .r_st(r_st), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err), .busy(busy),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_data_wr(mem_data_wr), .mem_data_rd(mem_data_rd)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  assign mem_data_rd = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr[7:2]] <= mem_data_wr;

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    int          t0;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          n_vec = 0, n_bad = 0, cyc = 0;
  int          m_nrd = 0, m_nwr = 0;
  logic [31:0] m_waddr = '0, m_wdata = '0;
  logic [31:0] model_rdata = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!r_st) begin
      m_nrd = 0;
      m_nwr = 0;
    end else begin
      if (mem_rd_en) m_nrd++;
      if (mem_wr_en) begin
        m_nwr++;
        m_waddr = mem_addr;
        m_wdata = mem_data_wr;
      end
      if (mem_rd_en && mem_wr_en) check("rd_wr_overlap", 32'd1, 32'd0);
      if (!done && err) check("err_without_done", {31'd0, err}, 32'd0);
      if (done) begin
        if (sbq.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else begin
          mon_e = sbq.pop_front();
          check({mon_e.name, "_err"}, {31'd0, err}, {31'd0, mon_e.err});
          check({mon_e.name, "_rdata"}, rdata, mon_e.rdata);
          check({mon_e.name, "_latency"}, cyc - mon_e.t0, mon_e.lat);
          check({mon_e.name, "_nrd"}, m_nrd, mon_e.nrd);
          check({mon_e.name, "_nwr"}, m_nwr, mon_e.nwr);
          if (mon_e.nwr > 0) begin
            check({mon_e.name, "_waddr"}, m_waddr, mon_e.waddr);
            check({mon_e.name, "_wdata"}, m_wdata, mon_e.wdata);
          end
        end
        m_nrd = 0;
        m_nwr = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input string name, input logic we_i, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] d,
                       input logic e_err, input logic [31:0] e_rdata, input int lat,
                       input int nrd, input int nwr, input logic [31:0] wd, input logic hold);
    exp_t x;
    wait_idle();
    we = we_i; size = sz; sign_ext = sg; addr = a; wdata = d; req = 1'b1;
    if (!we_i && !e_err) model_rdata = e_rdata;
    x.name = name; x.err = e_err; x.rdata = model_rdata; x.lat = lat;
    x.nrd = nrd; x.nwr = nwr; x.waddr = {a[31:2], 2'b00}; x.wdata = wd; x.t0 = cyc;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    if (!hold) req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdata"}, rdata, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_data_wr"}, mem_data_wr, 32'd0);
    check({tag, "_ctl"}, {27'd0, done, err, busy, mem_wr_en, mem_rd_en}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[8'h20 >> 2] = 32'h80FF7F01;
    mem[8'h30 >> 2] = 32'h11223344;
    mem[8'h44 >> 2] = 32'h55667788;
    mem[63]         = 32'hA5000000;

    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    r_st = 1'b1;

    // word store then load
    issue("st_w_10", 1'b1, SIZE_W, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2, 0, 1, 32'hDEADBEEF, 1'b0);
    issue("ld_w_10", 1'b0, SIZE_W, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2, 1, 0, 32'h0, 1'b0);
    // byte loads, word 0x80FF7F01 at 0x20
    issue("ld_b_23_s", 1'b0, SIZE_B, 1'b1, 32'h23, 32'h0, 1'b0, 32'hFFFFFF80, 2, 1, 0, 32'h0, 1'b0);
    issue("ld_b_23_z", 1'b0, SIZE_B, 1'b0, 32'h23, 32'h0, 1'b0, 32'h00000080, 2, 1, 0, 32'h0, 1'b0);
    issue("ld_b_21_s", 1'b0, SIZE_B, 1'b1, 32'h21, 32'h0, 1'b0, 32'h0000007F, 2, 1, 0, 32'h0, 1'b0);
    issue("ld_b_22_s", 1'b0, SIZE_B, 1'b1, 32'h22, 32'h0, 1'b0, 32'hFFFFFFFF, 2, 1, 0, 32'h0, 1'b0);
    issue("ld_b_ff_s", 1'b0, SIZE_B, 1'b1, 32'hFF, 32'h0, 1'b0, 32'hFFFFFFA5, 2, 1, 0, 32'h0, 1'b0);
    // half store RMW and readback
    issue("st_h_32", 1'b1, SIZE_H, 1'b0, 32'h32, 32'h0000ABCD, 1'b0, 32'h0, 3, 1, 1, 32'hABCD3344, 1'b0);
    issue("ld_h_32_s", 1'b0, SIZE_H, 1'b1, 32'h32, 32'h0, 1'b0, 32'hFFFFABCD, 2, 1, 0, 32'h0, 1'b0);
    issue("st_b_31", 1'b1, SIZE_B, 1'b0, 32'h31, 32'h12345699, 1'b0, 32'h0, 3, 1, 1, 32'hABCD9944, 1'b0);
    // error requests: no memory access, rdata held
    issue("err_w_06", 1'b0, SIZE_W, 1'b0, 32'h06, 32'h0, 1'b1, 32'h0, 1, 0, 0, 32'h0, 1'b0);
    issue("err_h_41", 1'b1, SIZE_H, 1'b0, 32'h41, 32'h1234, 1'b1, 32'h0, 1, 0, 0, 32'h0, 1'b0);
    issue("err_sz11", 1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 1'b1, 32'h0, 1, 0, 0, 32'h0, 1'b0);
    issue("err_w_100", 1'b0, SIZE_W, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 1, 0, 0, 32'h0, 1'b0);
    // req held high across back-to-back loads
    issue("hold_w_20", 1'b0, SIZE_W, 1'b0, 32'h20, 32'h0, 1'b0, 32'h80FF7F01, 2, 1, 0, 32'h0, 1'b1);
    issue("hold_b_22", 1'b0, SIZE_B, 1'b0, 32'h22, 32'h0, 1'b0, 32'h000000FF, 2, 1, 0, 32'h0, 1'b1);
    issue("hold_h_20", 1'b0, SIZE_H, 1'b1, 32'h20, 32'h0, 1'b0, 32'h00007F01, 2, 1, 0, 32'h0, 1'b1);
    issue("hold_h_22", 1'b0, SIZE_H, 1'b1, 32'h22, 32'h0, 1'b0, 32'hFFFF80FF, 2, 1, 0, 32'h0, 1'b1);
    wait_idle();
    req = 1'b0;
    wait_idle();
    check("queue_drained", sbq.size(), 32'd0);

    // reset during WR of a byte store to 0x44
    we = 1'b1; size = SIZE_B; sign_ext = 1'b0; addr = 32'h44; wdata = 32'h000000AA; req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    n = 0;
    @(negedge clk);
    while (!mem_wr_en && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_wr", {31'd0, mem_wr_en}, 32'd1);
    check("rst_merge_word", mem_data_wr, 32'h556677AA);
    r_st = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk);
    @(negedge clk);
    r_st = 1'b1;
    model_rdata = '0;
    @(negedge clk);
    check_reset_outputs("rst_after");
    check("rst_mem_44", mem[8'h44 >> 2], 32'h55667788);
    check("rst_queue", sbq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
